// File: rtl/n64a_vsync_info_pkg.sv
// Shared constants for the N64 video sync tracker: bus width, sync-word bit
// positions, PAL threshold, RGB phase encodings and the field-state type.
package n64a_vsync_info_pkg;
  localparam int color_width_i  = 7;
  localparam int VSYNC          = 3;
  localparam int CLAMP          = 2;
  localparam int HSYNC          = 1;
  localparam int CSYNC          = 0;
  localparam int PAL_LINE_THRES = 287;

  localparam logic [1:0] DCNT_IDLE = 2'b00;
  localparam logic [1:0] DCNT_R    = 2'b01;
  localparam logic [1:0] DCNT_G    = 2'b10;
  localparam logic [1:0] DCNT_B    = 2'b11;

  typedef enum logic [1:0] {FLD_ARM, FLD_FIRST, FLD_RUN} fld_st_t;
endpackage

// File: rtl/n64a_vline_cnt.sv
// Saturating line counter; reload (to 0 or 1) takes priority over increment.
module n64a_vline_cnt #(
  parameter int LINE_CNT_W = 10
) (
  input  logic                  VCLK,
  input  logic                  RST,
  input  logic                  inc,
  input  logic                  reload,
  input  logic                  reload_val,
  output logic [LINE_CNT_W-1:0] cnt
);
  always_ff @(posedge VCLK or posedge RST) begin
    if (RST)
      cnt <= '0;
    else if (reload)
      cnt <= {{(LINE_CNT_W-1){1'b0}}, reload_val};
    else if (inc && !(&cnt))
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/n64a_vsync_info.sv
// nVDSYNC phase tracking, lines-per-field counting and PAL/480i/field detection.
// Define N64A_480I_DETECT_EN to enable n64_480i / field_id.
module n64a_vsync_info #(
  parameter int color_width_i  = n64a_vsync_info_pkg::color_width_i,
  parameter int LINE_CNT_W     = 10,
  parameter int PAL_LINE_THRES = n64a_vsync_info_pkg::PAL_LINE_THRES
) (
  input  logic                     VCLK,
  input  logic                     RST,
  input  logic                     nVDSYNC,
  input  logic [color_width_i-1:0] VD_i,
  output logic [1:0]               data_cnt,
  output logic                     vmode,
  output logic                     n64_480i,
  output logic                     field_id,
  output logic                     vinfo_valid
);
  import n64a_vsync_info_pkg::*;

  localparam logic [LINE_CNT_W-1:0] PAL_THR = PAL_LINE_THRES[LINE_CNT_W-1:0];

  logic                  nvsync_q, nhsync_q;
  logic                  sync_word, vs_fall, hs_fall, pal;
  logic [LINE_CNT_W-1:0] lines;
  fld_st_t               fld_st;

  assign sync_word = ~nVDSYNC;
  assign vs_fall   = sync_word & nvsync_q & ~VD_i[VSYNC];
  assign hs_fall   = sync_word & nhsync_q & ~VD_i[HSYNC];
  assign pal       = lines > PAL_THR;

  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      data_cnt <= DCNT_IDLE;
      nvsync_q <= 1'b1;
      nhsync_q <= 1'b1;
    end else begin
      data_cnt <= sync_word ? DCNT_R : data_cnt + 2'd1;
      if (sync_word) begin
        nvsync_q <= VD_i[VSYNC];
        nhsync_q <= VD_i[HSYNC];
      end
    end
  end

  // A vsync fall that coincides with an hsync fall starts the new field at 1.
  n64a_vline_cnt #(.LINE_CNT_W(LINE_CNT_W)) u_line_cnt (
    .VCLK       (VCLK),
    .RST        (RST),
    .inc        (hs_fall),
    .reload     (vs_fall),
    .reload_val (hs_fall),
    .cnt        (lines)
  );

`ifdef N64A_480I_DETECT_EN
  logic last_lsb;
`else
  assign n64_480i = 1'b0;
  assign field_id = 1'b0;
`endif

  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      fld_st      <= FLD_ARM;
      vmode       <= 1'b0;
      vinfo_valid <= 1'b0;
`ifdef N64A_480I_DETECT_EN
      last_lsb    <= 1'b0;
      n64_480i    <= 1'b0;
      field_id    <= 1'b0;
`endif
    end else if (vs_fall) begin
      case (fld_st)
        FLD_ARM: fld_st <= FLD_FIRST;
        FLD_FIRST: begin
          vmode  <= pal;
          fld_st <= FLD_RUN;
`ifdef N64A_480I_DETECT_EN
          last_lsb <= lines[0];
`endif
        end
        default: begin
          vmode       <= pal;
          vinfo_valid <= 1'b1;
          fld_st      <= FLD_RUN;
`ifdef N64A_480I_DETECT_EN
          n64_480i <= lines[0] ^ last_lsb;
          field_id <= lines[0];
          last_lsb <= lines[0];
`endif
        end
      endcase
    end
  end

  logic unused_vd;
  assign unused_vd = ^{VD_i[color_width_i-1:VSYNC+1], VD_i[CLAMP], VD_i[CSYNC]};
endmodule

// File: tb/tb_n64a_vsync_info.sv
// Directed bench for n64a_vsync_info: field-level reference model plus literal checks.
module tb_n64a_vsync_info;
`ifdef N64A_480I_DETECT_EN
  localparam bit DET = 1'b1;
`else
  localparam bit DET = 1'b0;
`endif

  logic       VCLK = 1'b0;
  logic       RST  = 1'b0;
  logic       nVDSYNC = 1'b1;
  logic [6:0] VD_i = '1;
  logic [1:0] data_cnt;
  logic       vmode, n64_480i, field_id, vinfo_valid;

  int nvec = 0;
  int nerr = 0;

  n64a_vsync_info dut (
    .VCLK(VCLK), .RST(RST), .nVDSYNC(nVDSYNC), .VD_i(VD_i),
    .data_cnt(data_cnt), .vmode(vmode), .n64_480i(n64_480i),
    .field_id(field_id), .vinfo_valid(vinfo_valid)
  );

  always #5 VCLK = ~VCLK;

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: words since last sync word, field lengths seen at each vsync fall.
  int m_phase = 0, m_lines = 0, m_falls = 0;
  bit m_vs = 1'b1, m_hs = 1'b1, vsf, hsf;
  int fields[$];

  always @(posedge VCLK or posedge RST) begin
    if (RST) begin
      m_phase = 0; m_lines = 0; m_falls = 0; m_vs = 1'b1; m_hs = 1'b1;
      fields.delete();
    end else begin
      vsf = !nVDSYNC && m_vs && !VD_i[3];
      hsf = !nVDSYNC && m_hs && !VD_i[1];
      if (!nVDSYNC) begin m_vs = VD_i[3]; m_hs = VD_i[1]; end
      m_phase = nVDSYNC ? (m_phase + 1) % 4 : 1;
      if (vsf) begin
        m_falls++;
        if (m_falls >= 2) fields.push_back(m_lines);
        m_lines = hsf ? 1 : 0;
      end else if (hsf && m_lines < 1023) m_lines++;
    end
  end

  int e_vmode, e_480i, e_fid, e_valid;
  always @(negedge VCLK) begin
    e_vmode = (m_falls >= 2) ? int'(fields[$] > 287) : 0;
    e_valid = (m_falls >= 3) ? 1 : 0;
    e_480i  = (DET && m_falls >= 3) ? int'(fields[$][0] != fields[$-1][0]) : 0;
    e_fid   = (DET && m_falls >= 3) ? int'(fields[$][0]) : 0;
    chk("data_cnt", data_cnt, m_phase);
    chk("vmode", vmode, e_vmode);
    chk("n64_480i", n64_480i, e_480i);
    chk("field_id", field_id, e_fid);
    chk("vinfo_valid", vinfo_valid, e_valid);
  end

  // Each word is applied away from the edge and held for exactly one VCLK.
  task automatic word(input logic nv, input logic vs, input logic hs);
    nVDSYNC = nv;
    VD_i = nv ? 7'($urandom) : {3'b101, vs, 1'b1, hs, 1'b0};
    @(posedge VCLK); #1;
  endtask

  task automatic group(input logic vs, input logic hs);
    word(1'b0, vs, hs);
    repeat (3) word(1'b1, 1'b1, 1'b1);
  endtask

  task automatic field(input int n);
    repeat (n) begin group(1'b1, 1'b0); group(1'b1, 1'b1); end
  endtask

  task automatic fall(input bit simul);
    group(1'b0, !simul);
    group(1'b1, 1'b1);
  endtask

  task automatic reset_dut();
    RST = 1'b1;
    @(posedge VCLK); #1;
    RST = 1'b0;
  endtask

  task automatic lit_mode(input string nm, input int vm, input int i4, input int fid, input int vl);
    chk({nm, "_vmode"}, vmode, vm);
    chk({nm, "_480i"}, n64_480i, DET ? i4 : 0);
    chk({nm, "_fid"}, field_id, DET ? fid : 0);
    chk({nm, "_valid"}, vinfo_valid, vl);
  endtask

  int ph_exp [4] = '{1, 2, 3, 0};

  initial begin
    #1 RST = 1'b1;
    #13 RST = 1'b0;
    @(posedge VCLK); #1;
    lit_mode("reset", 0, 0, 0, 0);
    repeat (5) word(1'b1, 1'b1, 1'b1);

    // phase cadence
    repeat (2) for (int i = 0; i < 4; i++) begin
      word(i == 0 ? 1'b0 : 1'b1, 1'b1, 1'b1);
      chk("phase", data_cnt, ph_exp[i]);
    end

    // NTSC 240p
    field(263); fall(0);
    chk("ntsc_arm_valid", vinfo_valid, 0);
    field(263); fall(0);
    chk("ntsc_first_valid", vinfo_valid, 0);
    field(263); fall(0);
    lit_mode("ntsc", 0, 0, 1, 1);

    // PAL 480i
    reset_dut();
    field(40); fall(0);
    field(313); fall(0);
    field(312); fall(0);
    lit_mode("pal_f3", 1, 1, 0, 1);
    field(313); fall(0);
    lit_mode("pal_f4", 1, 1, 1, 1);
    field(312); fall(0);
    lit_mode("pal_f5", 1, 1, 0, 1);

    // simultaneous hsync/vsync fall, then threshold boundary 287/288
    reset_dut();
    field(5); fall(1);
    field(262); fall(0);
    chk("simul_model_cnt", fields[$], 263);
    lit_mode("simul", 0, 0, 0, 0);
    field(287); fall(0);
    lit_mode("thr287", 0, 0, 1, 1);
    field(288); fall(0);
    lit_mode("thr288", 1, 1, 0, 1);

    // saturation
    reset_dut();
    fall(0);
    field(10); fall(0);
    chk("sat_pre_vmode", vmode, 0);
    field(1100);
    chk("sat_model_cnt", m_lines, 1023);
    fall(0);
    lit_mode("sat", 1, 1, 1, 1);

    // mid-field reset
    reset_dut();
    fall(0); field(20); fall(0); field(21); fall(0);
    lit_mode("pre_rst", 0, 1, 1, 1);
    field(100);
    #2 RST = 1'b1;
    #1;
    chk("rst_dcnt", data_cnt, 0);
    lit_mode("rst", 0, 0, 0, 0);
    @(posedge VCLK); #1;
    RST = 1'b0;
    field(50); fall(0);
    lit_mode("rst_arm", 0, 0, 0, 0);
    field(300); fall(0);
    lit_mode("rst_first", 1, 0, 0, 0);
    field(21); fall(0);
    lit_mode("rst_run", 0, 1, 1, 1);

    repeat (3) word(1'b1, 1'b1, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
